uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
- Reader end of the byte FIFO: pops bytes from a FIFO through its rd_en/rd_data/empty handshake and serializes each byte as a UART frame on tx toward the ESP8266.
- Frame format: 1 start bit, DATA_WIDTH data bits LSB first, optional parity bit, 1 stop bit.
- Sits between the TX FIFO and the FPGA pin driving the ESP8266 RX line.

Parameters:
- DATA_WIDTH, 8, bits per character; also the width of fifo_rd_data.
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); must be >= 2.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- tx_enable, input, 1, permits fetching a new byte. When low, no new pop starts; a frame already in progress always completes.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_rd_data, input, DATA_WIDTH, FIFO read data. It is registered in the FIFO and valid on the edge after the rd_en cycle.
- fifo_rd_en, output, 1, registered pop request; a single-cycle pulse per byte.
- tx, output, 1, registered serial line; idles high.
- busy, output, 1, high in every state other than IDLE.
- tx_done, output, 1, registered single-cycle pulse when a stop bit completes.

Behaviour:
- Reset: single clock and reset; reset is synchronous and active-high.
  - rst high at an edge forces state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, and clears the bit counter and baud counter.
  - Reset mid-frame aborts the frame: tx returns high on that edge and the popped byte is discarded.
- States: IDLE, REQ, LATCH, START, DATA, PARITY, STOP.
- IDLE:
  - If tx_enable && !fifo_empty: fifo_rd_en<=1, go to REQ.
  - Otherwise stay; tx=1.
- REQ: fifo_rd_en<=0. The FIFO pops on this edge. Go to LATCH.
- LATCH: shift_reg<=fifo_rd_data; compute the parity bit; tx<=0; baud counter<=0; go to START.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
  - A bit ends when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
  - Each bit holds tx for exactly CLKS_PER_BIT cycles.
- START: at bit end, tx<=shift_reg[0], bit index<=0, go to DATA.
- DATA:
  - At each bit end, shift right and drive the next bit on tx.
  - After bit DATA_WIDTH-1, go to PARITY (PARITY!=0) or STOP (tx<=1).
- PARITY:
  - Parity bit: even = XOR of the data bits; odd = its inverse.
  - At bit end: tx<=1, go to STOP.
- STOP: at bit end, tx_done<=1 for one cycle, go to IDLE. tx stays 1.
- Timing:
  - Latency from fifo_empty falling (IDLE, tx_enable=1) to tx falling: 3 edges.
  - Frame length: (DATA_WIDTH+2+(PARITY!=0))*CLKS_PER_BIT cycles.
  - Back-to-back bytes: tx is high for exactly 3 cycles beyond the stop bit.
- Exactly one fifo_rd_en pulse per frame.
  - fifo_empty is sampled only in IDLE. The FIFO count has already updated by then, so no double pop occurs.
  - fifo_rd_en is never asserted while fifo_empty=1.
- tx_enable is sampled only in IDLE; deasserting it mid-frame has no effect on the current frame.
- Changes to fifo_rd_data outside LATCH are ignored.

Test Plan:
- Reset check (CLKS_PER_BIT=4, PARITY=0): assert rst for 2 cycles with the FIFO non-empty -> tx=1, busy=0, fifo_rd_en=0, tx_done=0 throughout.
- Single byte 0xA5, PARITY=0, CLKS_PER_BIT=4:
  - Exactly one 1-cycle fifo_rd_en pulse.
  - tx falls 3 edges after empty falls, then carries 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
  - One tx_done pulse, then busy=0.
- Back-to-back 0x55 then 0x0F:
  - Exactly two rd_en pulses.
  - tx high for exactly 3 cycles between the first stop bit and the second start bit.
  - The second frame data is 1,1,1,1,0,0,0,0.
- Parity, byte 0x07:
  - PARITY=1: parity bit=1, frame 11 bits = 44 cycles.
  - PARITY=2: parity bit=0.
- Flow control:
  - tx_enable=0 with the FIFO non-empty -> no rd_en and tx=1 for 100 cycles.
  - Drop tx_enable during data bit 3 -> the frame completes and no further rd_en occurs.
- Reset mid-frame: rst during data bit 4 -> tx=1 on the next edge and busy=0. After release with the FIFO non-empty, the next byte's frame starts 3 edges later.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// ============================================================================
// Module   : uart_tx_fifo_drain
// Brief    : Pops bytes from a registered-read FIFO and serializes each one
//            as a UART frame (start, LSB-first data, optional parity, stop).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_MAX  = c_IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_LATCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t                  r_state;
    logic [c_BAUD_W-1:0]     r_baud;
    logic [c_IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_parity;

    logic                    w_bit_end;
    logic [DATA_WIDTH-1:0]   w_shift_nxt;

    assign w_bit_end   = (r_baud == c_BAUD_MAX);
    assign w_shift_nxt = r_shift >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Baud counter free-runs across all on-line states; LATCH seeds it.
            if (r_state inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
                r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (tx_enable && !fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    fifo_rd_en <= 1'b0;
                    r_state    <= S_LATCH;
                end
                S_LATCH: begin
                    r_shift  <= fifo_rd_data;
                    r_parity <= (PARITY == 2) ? ~^fifo_rd_data : ^fifo_rd_data;
                    tx       <= 1'b0;
                    r_baud   <= '0;
                    r_state  <= S_START;
                end
                S_START: begin
                    if (w_bit_end) begin
                        tx      <= r_shift[0];
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == c_IDX_MAX) begin
                            if (PARITY != 0) begin
                                tx      <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                tx      <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            tx      <= w_shift_nxt[0];
                            r_shift <= w_shift_nxt;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        tx      <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        tx_done <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
// ============================================================================
// Module   : tb_uart_tx_fifo_drain
// Brief    : Directed, table-driven bench for uart_tx_fifo_drain with a
//            registered-read FIFO model and a parity-enabled pair of instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo_drain;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_enable;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_en, tx, busy, tx_done;

    logic       p_en, p_empty;
    logic [7:0] p_data = 8'h07;
    logic       p1_rd_en, p1_tx, p1_busy, p1_done;
    logic       p2_rd_en, p2_tx, p2_busy, p2_done;

    logic       push_req;
    logic [7:0] push_data;
    logic [7:0] q[$];

    int n_vec = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int rd_when_empty = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY(0)) dut (
        .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .tx(tx),
        .busy(busy), .tx_done(tx_done)
    );

    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY(1)) dut_even (
        .clk(clk), .rst(rst), .tx_enable(p_en), .fifo_empty(p_empty),
        .fifo_rd_data(p_data), .fifo_rd_en(p1_rd_en), .tx(p1_tx),
        .busy(p1_busy), .tx_done(p1_done)
    );

    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY(2)) dut_odd (
        .clk(clk), .rst(rst), .tx_enable(p_en), .fifo_empty(p_empty),
        .fifo_rd_data(p_data), .fifo_rd_en(p2_rd_en), .tx(p2_tx),
        .busy(p2_busy), .tx_done(p2_done)
    );

    // FIFO model: registered read data, registered empty flag
    always @(posedge clk) begin
        if (fifo_rd_en && q.size() > 0) fifo_rd_data <= q.pop_front();
        if (push_req) q.push_back(push_data);
        fifo_empty <= (q.size() == 0);
    end

    always @(negedge clk) begin
        if (fifo_rd_en) rd_cnt++;
        if (fifo_rd_en && fifo_empty) rd_when_empty++;
    end

    typedef struct {
        logic [7:0]  data;
        logic [15:0] frame;
    } vec_t;
    vec_t tbl[3];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic push(input logic [7:0] d);
        push_data = d;
        push_req  = 1'b1;
        @(posedge clk); #1;
        push_req  = 1'b0;
    endtask

    task automatic tx_fall_latency(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (tx !== 1'b0 && n < 20);
    endtask

    // Entered on the first sample of the start bit; returns on the sample after the stop bit.
    task automatic check_frame(input string name, input logic [15:0] exp,
                               input int nbits, input int drop_at);
        int          hold_err = 0;
        int          early    = 0;
        logic [15:0] got      = '0;
        for (int k = 0; k < nbits * C; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (tx !== exp[k / C]) hold_err++;
            if (k % C == C / 2) got[k / C] = tx;
            if (tx_done !== 1'b0) early++;
            if (k == drop_at) tx_enable = 1'b0;
        end
        check({name, ".bits"}, 32'(got), 32'(exp));
        check({name, ".hold"}, hold_err, 0);
        check({name, ".early_done"}, early, 0);
        @(posedge clk); #1;
        check({name, ".done_tx_busy"}, {29'd0, tx_done, busy, tx}, 32'b101);
    endtask

    initial begin
        int          n, m, g, rd0, hi_err;
        logic [15:0] got1, got2;
        logic [15:0] exp1, exp2;

        tbl[0] = '{8'h00, 16'b1_00000000_0};
        tbl[1] = '{8'hFF, 16'b1_11111111_0};
        tbl[2] = '{8'h3C, 16'b1_00111100_0};

        rst = 1'b1; tx_enable = 1'b1; push_req = 1'b0; push_data = 8'h00;
        p_en = 1'b0; p_empty = 1'b1;
        @(posedge clk); #1;

        // Reset held with the FIFO non-empty
        push(8'hA5);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("reset.c%0d", i), {28'd0, tx, busy, fifo_rd_en, tx_done}, 32'b1000);
        end
        rd0 = rd_cnt;
        rst = 1'b0;
        tx_fall_latency(n);
        check("a5.latency", n, 3);
        check_frame("a5", 16'b1_10100101_0, 10, -1);
        @(posedge clk); #1;
        check("a5.idle", {29'd0, tx, busy, tx_done}, 32'b100);
        check("a5.rd_pulses", rd_cnt - rd0, 1);

        for (int i = 0; i < 3; i++) begin
            rd0 = rd_cnt;
            push(tbl[i].data);
            tx_fall_latency(n);
            check($sformatf("vec%0d.latency", i), n, 3);
            check_frame($sformatf("vec%0d", i), tbl[i].frame, 10, -1);
            @(posedge clk); #1;
            check($sformatf("vec%0d.idle", i), {29'd0, tx, busy, tx_done}, 32'b100);
            check($sformatf("vec%0d.rd_pulses", i), rd_cnt - rd0, 1);
        end

        // Back-to-back 0x55 then 0x0F
        tx_enable = 1'b0;
        push(8'h55);
        push(8'h0F);
        rd0 = rd_cnt;
        tx_enable = 1'b1;
        tx_fall_latency(n);
        check("b2b.latency", n, 3);
        check_frame("b2b0", 16'b1_01010101_0, 10, -1);
        g = 1;
        while (g < 20) begin
            @(posedge clk); #1;
            if (tx === 1'b0) break;
            g++;
        end
        check("b2b.gap", g, 3);
        check_frame("b2b1", 16'b1_00001111_0, 10, -1);
        @(posedge clk); #1;
        check("b2b.rd_pulses", rd_cnt - rd0, 2);

        // Flow control: disabled with data waiting
        tx_enable = 1'b0;
        rd0 = rd_cnt;
        push(8'h81);
        hi_err = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) hi_err++;
        end
        check("flow.no_rd", rd_cnt - rd0, 0);
        check("flow.line_idle", hi_err, 0);
        push(8'hC3);
        tx_enable = 1'b1;
        tx_fall_latency(n);
        check("flow.latency", n, 3);
        check_frame("flow", 16'b1_10000001_0, 10, 4 * C + 1);
        hi_err = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) hi_err++;
        end
        check("flow.stopped_line", hi_err, 0);
        check("flow.rd_pulses", rd_cnt - rd0, 1);

        // Reset during data bit 4 of 0xC3; 0x5A follows
        push(8'h5A);
        rd0 = rd_cnt;
        tx_enable = 1'b1;
        tx_fall_latency(n);
        check("abort.latency", n, 3);
        for (int k = 1; k <= 5 * C + 1; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort.reset_out", {28'd0, tx, busy, fifo_rd_en, tx_done}, 32'b1000);
        rst = 1'b0;
        tx_fall_latency(n);
        check("abort.restart_latency", n, 3);
        check_frame("post_rst", 16'b1_01011010_0, 10, -1);
        check("abort.rd_pulses", rd_cnt - rd0, 2);

        // Parity: 0x07 on the even and odd instances side by side
        exp1 = 16'b1_1_00000111_0;
        exp2 = 16'b1_0_00000111_0;
        p_en = 1'b1; p_empty = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (p1_rd_en !== 1'b1 && n < 10);
        p_empty = 1'b1;
        check("par.rd_latency", n, 1);
        m = 0;
        do begin
            @(posedge clk); #1;
            m++;
        end while (p1_tx !== 1'b0 && m < 10);
        check("par.latency", n + m, 3);
        got1 = '0; got2 = '0;
        for (int k = 0; k < 11 * C; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k % C == C / 2) begin
                got1[k / C] = p1_tx;
                got2[k / C] = p2_tx;
            end
        end
        check("par.even_bits", 32'(got1), 32'(exp1));
        check("par.odd_bits", 32'(got2), 32'(exp2));
        @(posedge clk); #1;
        check("par.done_at_44", {30'd0, p1_done, p2_done}, 32'b11);
        p_en = 1'b0;

        check("rd_when_empty", rd_when_empty, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
